afu_cmd_credit_arbiter: RTL and testbench
=========================================

// Module: afu_cmd_credit_arbiter
// PURPOSE
//  Command-issue stage between the read/write command buffers and the PSL command port.
//  Arbitrates read vs write requests and gates each class on its own credit pool.
//  Assigns a non-zero command tag to each issued command.
//  Returns credits on responses and counts completions for the DONE_READ/WRITE_COUNT_REG MMIO registers.
// PARAMETERS
//  CREDITS_READ   32   max outstanding read commands
//  CREDITS_WRITE  32   max outstanding write commands
//  CREDIT_BITS    $clog2(max(CREDITS_READ,CREDITS_WRITE)+1)  credit counter width (6 at defaults)
//  Constraint: CREDITS_READ+CREDITS_WRITE <= 64, checked at elaboration; fatal if exceeded.
// PORTS
//  clock             in   1            single clock, all logic posedge
//  rstn              in   1            asynchronous, active-low reset
//  enabled           in   1            0: no grants (responses still processed)
//  rd_req_valid      in   1            read command request pending
//  rd_req_ready      out  1            read request accepted this cycle
//  wr_req_valid      in   1            write command request pending
//  wr_req_ready      out  1            write request accepted this cycle
//  cmd_valid         out  1            registered command strobe to PSL
//  cmd_is_write      out  1            1=write, 0=read; valid with cmd_valid
//  cmd_tag           out  8            tag; never INVALID_TAG (8'h00)
//  rsp_valid         in   1            PSL response strobe, one command retired
//  rsp_is_write      in   1            class of retired command
//  rd_credits        out  CREDIT_BITS  free read credits
//  wr_credits        out  CREDIT_BITS  free write credits
//  done_read_count   out  64           read responses since reset
//  done_write_count  out  64           write responses since reset
//  credit_error      out  1            sticky overflow flag
// BEHAVIOUR
//  Reset values:
//   - rd_credits=CREDITS_READ, wr_credits=CREDITS_WRITE.
//   - cmd_valid=0, cmd_is_write=0, cmd_tag=8'h00.
//   - done counts=0, credit_error=0, internal tag counter=8'h01, last_grant_write=1.
//  Eligibility:
//   - rd_elig = enabled & rd_req_valid & (rd_credits!=0).
//   - wr_elig = enabled & wr_req_valid & (wr_credits!=0).
//  Grant (combinational, at most one ready per cycle):
//   - Only one eligible: that class is granted.
//   - Both eligible: grant the class opposite last_grant_write (round-robin; read first after reset).
//   - rd_req_ready / wr_req_ready are the grant signals. A handshake is valid&ready.
//  Issue, latency 1:
//   - On a handshake edge: cmd_valid<=1, cmd_is_write<=class, cmd_tag<=tag counter.
//   - Same edge: that class's credit decrements, last_grant_write<=class, tag counter advances.
//   - No handshake: cmd_valid<=0; cmd_is_write and cmd_tag hold.
//   - Sustained issue is one command per cycle.
//  Tag counter: increments per issue; 8'hFF wraps to 8'h01, never 8'h00.
//  Response: rsp_valid increments the class credit and that class's done count, same edge.
//   - Issue and response of the same class in the same cycle: credit unchanged, done count +1.
//   - Issue and response of different classes: both updates apply independently.
//   - Credit already at max on a response, with no same-class issue that cycle:
//     credit holds (saturates), credit_error<=1. Done count still increments.
//   - credit_error stays set until rstn.
//  Credit 0: the class is not eligible; the other class may take every cycle.
//  enabled=0: no ready asserted. Credits, done counts and tag counter change only via responses.
//  Done counts wrap modulo 2^64.
//  Reset mid-operation: all state returns to reset values immediately, asynchronously.
//   - Stale responses after reset are counted and may raise credit_error (expected, not masked).
// TESTING
//  T1 reset, rd_req_valid=1 held 40 cycles, no responses -> 32 cmds (tags 1..32),
//     rd_credits=0, then rd_req_ready=0.
//  T2 rd and wr valid held, no responses -> cmd_is_write alternates 0,1,0,1...
//     rd_credits and wr_credits both decrement to 0 together.
//  T3 rd_credits=0, wr valid -> writes granted every cycle.
//     One read rsp -> rd_credits=1, next read granted within 2 cycles.
//  T4 one issue and one same-class rsp per cycle for 300 cycles ->
//     credits steady, done_read_count=300, tag sequence ...,FF,01,02 (00 never seen).
//  T5 rsp_valid with rd_credits=32 -> rd_credits stays 32, credit_error=1 until rstn pulse,
//     done_read_count=1.
//  T6 rstn low mid-burst, async -> cmd_valid=0 before the next clock edge,
//     all counters back to reset values.

Source files
------------

// File: rtl/afu_cmd_credit_arbiter.sv
// -----------------------------------------------------------------------------
// afu_cmd_credit_arbiter
//
// Command-issue stage between the read/write command buffers and the PSL
// command port. Each cycle it picks at most one of the pending read/write
// requests. Each class has its own credit pool, and a class with no free
// credits cannot be picked. Every issued command gets a non-zero tag.
// Responses return credits and are counted for the completion-count MMIO
// registers.
//
// Ports
//   clock             in   single clock, all logic on posedge
//   rstn              in   asynchronous active-low reset
//   enabled           in   0 blocks all grants; responses are still processed
//   rd_req_valid      in   read command request pending
//   rd_req_ready      out  read request accepted this cycle (combinational grant)
//   wr_req_valid      in   write command request pending
//   wr_req_ready      out  write request accepted this cycle (combinational grant)
//   cmd_valid         out  registered command strobe to PSL
//   cmd_is_write      out  1 = write, 0 = read; meaningful with cmd_valid
//   cmd_tag           out  command tag, never 8'h00 while cmd_valid
//   rsp_valid         in   PSL response strobe, retires one command
//   rsp_is_write      in   class of the retired command
//   rd_credits        out  free read credits
//   wr_credits        out  free write credits
//   done_read_count   out  read responses since reset (wraps mod 2^64)
//   done_write_count  out  write responses since reset (wraps mod 2^64)
//   credit_error      out  sticky: a response arrived with the pool already full
// -----------------------------------------------------------------------------
module afu_cmd_credit_arbiter #(
    parameter int CREDITS_READ  = 32,
    parameter int CREDITS_WRITE = 32,
    parameter int CREDIT_BITS   =
        $clog2(((CREDITS_READ > CREDITS_WRITE) ? CREDITS_READ : CREDITS_WRITE) + 1)
) (
    input  logic                   clock,
    input  logic                   rstn,
    input  logic                   enabled,
    input  logic                   rd_req_valid,
    output logic                   rd_req_ready,
    input  logic                   wr_req_valid,
    output logic                   wr_req_ready,
    output logic                   cmd_valid,
    output logic                   cmd_is_write,
    output logic [7:0]             cmd_tag,
    input  logic                   rsp_valid,
    input  logic                   rsp_is_write,
    output logic [CREDIT_BITS-1:0] rd_credits,
    output logic [CREDIT_BITS-1:0] wr_credits,
    output logic [63:0]            done_read_count,
    output logic [63:0]            done_write_count,
    output logic                   credit_error
);

    // Class index 0 is read and class index 1 is write. Using the same index
    // for both classes lets one generate loop build both credit pools.
    localparam int         NUM_CLASSES = 2;
    localparam logic [7:0] INVALID_TAG = 8'h00;
    localparam logic [7:0] FIRST_TAG   = 8'h01;
    localparam logic [7:0] LAST_TAG    = 8'hFF;

    // The combined pool must fit the 64-entry outstanding-command window.
    // Each pool also needs at least one credit.
    generate
        if ((CREDITS_READ + CREDITS_WRITE > 64) || (CREDITS_READ < 1) || (CREDITS_WRITE < 1))
        begin : g_credit_limit_check
            $fatal(1, "afu_cmd_credit_arbiter: illegal credit configuration");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Per-class request / grant / response vectors
    // -------------------------------------------------------------------------
    logic [NUM_CLASSES-1:0]                  w_req_valid;
    logic [NUM_CLASSES-1:0]                  w_elig;
    logic [NUM_CLASSES-1:0]                  w_grant;
    logic [NUM_CLASSES-1:0]                  w_rsp;
    logic [NUM_CLASSES-1:0]                  w_overflow;
    logic [NUM_CLASSES-1:0][CREDIT_BITS-1:0] w_credit;
    logic [NUM_CLASSES-1:0][63:0]            w_done_count;
    logic                                    w_issue;

    // -------------------------------------------------------------------------
    // Issue-side state
    // -------------------------------------------------------------------------
    logic       r_cmd_valid;
    logic       r_cmd_is_write;
    logic [7:0] r_cmd_tag;
    logic [7:0] r_tag_ctr;
    logic [7:0] w_tag_ctr_next;
    logic       r_last_grant_write;
    logic       r_credit_error;

    assign w_req_valid = {wr_req_valid, rd_req_valid};

    // -------------------------------------------------------------------------
    // Credit pools and completion counters, one instance per class
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_class
            localparam logic [CREDIT_BITS-1:0] CREDIT_MAX =
                (gi == 0) ? CREDIT_BITS'(CREDITS_READ) : CREDIT_BITS'(CREDITS_WRITE);

            logic [CREDIT_BITS-1:0] r_credit;
            logic [CREDIT_BITS-1:0] w_credit_next;
            logic [63:0]            r_done_count;
            logic                   w_ovf;

            assign w_elig[gi] = enabled & w_req_valid[gi] & (r_credit != '0);
            assign w_rsp[gi]  = rsp_valid & (rsp_is_write == 1'(gi));

            // Issue takes a credit and a response returns one. When both happen
            // in the same cycle they cancel out. A response that finds the pool
            // already full is a protocol violation. In that case the count
            // saturates and the event is flagged instead of wrapping.
            always_comb begin
                w_credit_next = r_credit;
                w_ovf         = 1'b0;
                case ({w_grant[gi], w_rsp[gi]})
                    2'b10: w_credit_next = r_credit - 1'b1;
                    2'b01: begin
                        if (r_credit == CREDIT_MAX) begin
                            w_ovf = 1'b1;
                        end else begin
                            w_credit_next = r_credit + 1'b1;
                        end
                    end
                    default: w_credit_next = r_credit;
                endcase
            end

            always_ff @(posedge clock or negedge rstn) begin
                if (!rstn) begin
                    r_credit     <= CREDIT_MAX;
                    r_done_count <= '0;
                end else begin
                    r_credit <= w_credit_next;
                    if (w_rsp[gi]) begin
                        r_done_count <= r_done_count + 64'd1;
                    end
                end
            end

            assign w_overflow[gi]   = w_ovf;
            assign w_credit[gi]     = r_credit;
            assign w_done_count[gi] = r_done_count;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin grant
    // When only one class is eligible, that class wins. When both are eligible,
    // the class that did not win last time goes first. Reset sets
    // last_grant_write, so a read wins the first contested cycle.
    // -------------------------------------------------------------------------
    assign w_grant[0] = w_elig[0] & (~w_elig[1] |  r_last_grant_write);
    assign w_grant[1] = w_elig[1] & (~w_elig[0] | ~r_last_grant_write);
    assign w_issue    = |w_grant;

    // The tag counter skips the reserved value 8'h00 when it wraps.
    assign w_tag_ctr_next = (r_tag_ctr == LAST_TAG) ? FIRST_TAG : (r_tag_ctr + 8'd1);

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_cmd_valid        <= 1'b0;
            r_cmd_is_write     <= 1'b0;
            r_cmd_tag          <= INVALID_TAG;
            r_tag_ctr          <= FIRST_TAG;
            r_last_grant_write <= 1'b1;
            r_credit_error     <= 1'b0;
        end else begin
            r_cmd_valid <= w_issue;
            // Command fields hold their last value between strobes.
            if (w_issue) begin
                r_cmd_is_write     <= w_grant[1];
                r_cmd_tag          <= r_tag_ctr;
                r_tag_ctr          <= w_tag_ctr_next;
                r_last_grant_write <= w_grant[1];
            end
            // Sticky until the next reset.
            r_credit_error <= r_credit_error | (|w_overflow);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rd_req_ready     = w_grant[0];
    assign wr_req_ready     = w_grant[1];
    assign cmd_valid        = r_cmd_valid;
    assign cmd_is_write     = r_cmd_is_write;
    assign cmd_tag          = r_cmd_tag;
    assign rd_credits       = w_credit[0];
    assign wr_credits       = w_credit[1];
    assign done_read_count  = w_done_count[0];
    assign done_write_count = w_done_count[1];
    assign credit_error     = r_credit_error;

endmodule

// File: tb/tb_afu_cmd_credit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_afu_cmd_credit_arbiter
//
// Directed bench for afu_cmd_credit_arbiter at its default parameters
// (32 read and 32 write credits). It starts with a short table of per-cycle
// vectors whose expected values were worked out by hand. Hand-written
// sequences then cover draining the credits, read/write alternation, credit
// return, tag wrap, overflow and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_afu_cmd_credit_arbiter;

    localparam int CB = 6;

    logic          clock = 1'b0;
    logic          rstn;
    logic          enabled;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic          wr_req_valid;
    logic          wr_req_ready;
    logic          cmd_valid;
    logic          cmd_is_write;
    logic [7:0]    cmd_tag;
    logic          rsp_valid;
    logic          rsp_is_write;
    logic [CB-1:0] rd_credits;
    logic [CB-1:0] wr_credits;
    logic [63:0]   done_read_count;
    logic [63:0]   done_write_count;
    logic          credit_error;

    int   n_checks = 0;
    int   n_errors = 0;
    logic s_rd_rdy;
    logic s_wr_rdy;

    always #5 clock = ~clock;

    afu_cmd_credit_arbiter dut (
        .clock            (clock),
        .rstn             (rstn),
        .enabled          (enabled),
        .rd_req_valid     (rd_req_valid),
        .rd_req_ready     (rd_req_ready),
        .wr_req_valid     (wr_req_valid),
        .wr_req_ready     (wr_req_ready),
        .cmd_valid        (cmd_valid),
        .cmd_is_write     (cmd_is_write),
        .cmd_tag          (cmd_tag),
        .rsp_valid        (rsp_valid),
        .rsp_is_write     (rsp_is_write),
        .rd_credits       (rd_credits),
        .wr_credits       (wr_credits),
        .done_read_count  (done_read_count),
        .done_write_count (done_write_count),
        .credit_error     (credit_error)
    );

    typedef struct {
        logic       en;
        logic       rdv;
        logic       wrv;
        logic       rspv;
        logic       rspw;
        logic       x_rdy;
        logic       x_wrdy;
        logic       x_cv;
        logic       x_w;
        logic [7:0] x_tag;
        int         x_rc;
        int         x_wc;
        int         x_dr;
        int         x_dw;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle. Inputs are driven at the negedge and the grants are sampled
    // just after that. The registered outputs are sampled 1 time unit after
    // the posedge.
    task automatic step(input logic en, input logic rdv, input logic wrv,
                        input logic rspv, input logic rspw);
        @(negedge clock);
        enabled      = en;
        rd_req_valid = rdv;
        wr_req_valid = wrv;
        rsp_valid    = rspv;
        rsp_is_write = rspw;
        #1;
        s_rd_rdy = rd_req_ready;
        s_wr_rdy = wr_req_ready;
        @(posedge clock);
        #1;
        if (cmd_valid)
            $display("txn t=%0t cmd write=%0b tag=%02h rdc=%0d wrc=%0d", $time,
                     cmd_is_write, cmd_tag, rd_credits, wr_credits);
    endtask

    task automatic do_reset();
        rstn         = 1'b0;
        enabled      = 1'b0;
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        rsp_valid    = 1'b0;
        rsp_is_write = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_cmd_is_write", 64'(cmd_is_write), 64'd0);
        check("rst_cmd_tag", 64'(cmd_tag), 64'd0);
        check("rst_rd_credits", 64'(rd_credits), 64'd32);
        check("rst_wr_credits", 64'(wr_credits), 64'd32);
        check("rst_done_read", done_read_count, 64'd0);
        check("rst_done_write", done_write_count, 64'd0);
        check("rst_credit_error", 64'(credit_error), 64'd0);
        @(negedge clock);
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int found;

        //            en   rdv  wrv  rspv rspw | rdy  wrdy cv   w    tag    rc  wc  dr dw
        vecs[0] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 8'h00, 32, 32, 0, 0};
        vecs[1] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 8'h01, 31, 32, 0, 0};
        vecs[2] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1, 8'h02, 31, 31, 0, 0};
        vecs[3] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 8'h03, 30, 31, 0, 0};
        vecs[4] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1, 8'h04, 30, 30, 0, 0};
        vecs[5] = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1, 8'h04, 31, 30, 1, 0};
        vecs[6] = '{1'b1,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b1, 8'h05, 31, 30, 1, 1};
        vecs[7] = '{1'b1,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0, 8'h06, 30, 31, 1, 2};
        vecs[8] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b1, 8'h07, 31, 30, 2, 2};
        vecs[9] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1, 8'h07, 31, 30, 2, 2};

        // ---------------- table vectors ----------------
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].en, vecs[i].rdv, vecs[i].wrv, vecs[i].rspv, vecs[i].rspw);
            $display("vec %0d: rdy=%0b wrdy=%0b cv=%0b w=%0b tag=%02h rc=%0d wc=%0d", i,
                     s_rd_rdy, s_wr_rdy, cmd_valid, cmd_is_write, cmd_tag, rd_credits, wr_credits);
            check($sformatf("v%0d_rd_ready", i), 64'(s_rd_rdy), 64'(vecs[i].x_rdy));
            check($sformatf("v%0d_wr_ready", i), 64'(s_wr_rdy), 64'(vecs[i].x_wrdy));
            check($sformatf("v%0d_cmd_valid", i), 64'(cmd_valid), 64'(vecs[i].x_cv));
            check($sformatf("v%0d_cmd_is_write", i), 64'(cmd_is_write), 64'(vecs[i].x_w));
            check($sformatf("v%0d_cmd_tag", i), 64'(cmd_tag), 64'(vecs[i].x_tag));
            check($sformatf("v%0d_rd_credits", i), 64'(rd_credits), 64'(vecs[i].x_rc));
            check($sformatf("v%0d_wr_credits", i), 64'(wr_credits), 64'(vecs[i].x_wc));
            check($sformatf("v%0d_done_read", i), done_read_count, 64'(vecs[i].x_dr));
            check($sformatf("v%0d_done_write", i), done_write_count, 64'(vecs[i].x_dw));
        end
        check("vec_credit_error", 64'(credit_error), 64'd0);

        // ---------------- T1: drain read credits ----------------
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("t1_rd_ready_%0d", k), 64'(s_rd_rdy), 64'(k < 32));
            check($sformatf("t1_cmd_valid_%0d", k), 64'(cmd_valid), 64'(k < 32));
            check($sformatf("t1_cmd_tag_%0d", k), 64'(cmd_tag), 64'((k < 32) ? k + 1 : 32));
        end
        check("t1_rd_credits", 64'(rd_credits), 64'd0);
        check("t1_wr_credits", 64'(wr_credits), 64'd32);

        // ---------------- T2: alternation ----------------
        do_reset();
        for (int k = 0; k < 68; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("t2_rd_ready_%0d", k), 64'(s_rd_rdy), 64'((k < 64) && (k % 2 == 0)));
            check($sformatf("t2_wr_ready_%0d", k), 64'(s_wr_rdy), 64'((k < 64) && (k % 2 == 1)));
            check($sformatf("t2_cmd_valid_%0d", k), 64'(cmd_valid), 64'(k < 64));
            check($sformatf("t2_is_write_%0d", k), 64'(cmd_is_write), 64'((k < 64) ? (k % 2) : 1));
            if (k % 2 == 1) begin
                check($sformatf("t2_rd_credits_%0d", k), 64'(rd_credits),
                      64'((k < 64) ? 32 - (k + 1) / 2 : 0));
                check($sformatf("t2_wr_credits_%0d", k), 64'(wr_credits),
                      64'((k < 64) ? 32 - (k + 1) / 2 : 0));
            end
        end

        // ---------------- T3: read starved, then credit returned ----------------
        do_reset();
        for (int k = 0; k < 32; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_rd_credits_drained", 64'(rd_credits), 64'd0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("t3_rd_ready_%0d", k), 64'(s_rd_rdy), 64'd0);
            check($sformatf("t3_wr_ready_%0d", k), 64'(s_wr_rdy), 64'd1);
        end
        check("t3_wr_credits", 64'(wr_credits), 64'd27);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t3_rd_blocked", 64'(s_rd_rdy), 64'd0);
        check("t3_rd_credit_back", 64'(rd_credits), 64'd1);
        check("t3_done_read", done_read_count, 64'd1);
        found = 0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            if (s_rd_rdy) begin
                found = 1;
                break;
            end
        end
        check("t3_rd_regrant", 64'(found), 64'd1);
        check("t3_regrant_is_read", 64'(cmd_is_write), 64'd0);
        check("t3_rd_credits_after", 64'(rd_credits), 64'd0);

        // ---------------- T4: steady issue+response, tag wrap ----------------
        do_reset();
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            check($sformatf("t4_cmd_tag_%0d", k), 64'(cmd_tag), 64'((k % 255) + 1));
        end
        check("t4_rd_credits", 64'(rd_credits), 64'd32);
        check("t4_done_read", done_read_count, 64'd300);
        check("t4_done_write", done_write_count, 64'd0);
        check("t4_credit_error", 64'(credit_error), 64'd0);

        // ---------------- T5: response with full pool ----------------
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_rd_credits", 64'(rd_credits), 64'd32);
        check("t5_credit_error", 64'(credit_error), 64'd1);
        check("t5_done_read", done_read_count, 64'd1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_error_sticky", 64'(credit_error), 64'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t5_wr_credits", 64'(wr_credits), 64'd32);
        check("t5_done_write", done_write_count, 64'd1);
        do_reset();

        // ---------------- T6: async reset mid-burst ----------------
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t6_pre_cmd_valid", 64'(cmd_valid), 64'd1);
        check("t6_pre_rd_credits", 64'(rd_credits), 64'd29);
        check("t6_pre_done_read", done_read_count, 64'd1);
        #1;
        rstn = 1'b0;
        #1;
        check("t6_cmd_valid", 64'(cmd_valid), 64'd0);
        check("t6_cmd_tag", 64'(cmd_tag), 64'd0);
        check("t6_rd_credits", 64'(rd_credits), 64'd32);
        check("t6_done_read", done_read_count, 64'd0);
        @(negedge clock);
        enabled      = 1'b0;
        rd_req_valid = 1'b0;
        rsp_valid    = 1'b0;
        rstn         = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_idle_cmd_valid", 64'(cmd_valid), 64'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_first_tag", 64'(cmd_tag), 64'd1);
        check("t6_first_rd_credits", 64'(rd_credits), 64'd31);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
